// File: rtl/sint_window_minmax_if.sv
// rtl/sint_window_minmax_if.sv - sample input and result output handshake bundle for sint_window_minmax
//
// Purpose: groups the sample input stream and the result output stream of
// sint_window_minmax so that one interface instance carries both.
// Signals:
//   I_data    signed sample (WIDTH bits, two's complement)
//   I_valid   sample valid
//   I_ready   block can accept a sample
//   O_min     signed minimum of the window
//   O_max     signed maximum of the window
//   O_min_idx 0-based position of the minimum within the window
//   O_max_idx 0-based position of the maximum within the window
//   O_valid   result beat valid
//   O_ready   downstream accepts the result
// Modports:
//   master  the producer of samples and consumer of results
//   slave   the min/max block itself
interface sint_window_minmax_if #(
  parameter int WIDTH = 3,
  parameter int IDXW  = 2
);
  logic [WIDTH-1:0] I_data;
  logic             I_valid;
  logic             I_ready;
  logic [WIDTH-1:0] O_min;
  logic [WIDTH-1:0] O_max;
  logic [IDXW-1:0]  O_min_idx;
  logic [IDXW-1:0]  O_max_idx;
  logic             O_valid;
  logic             O_ready;

  modport master (
    output I_data, I_valid, O_ready,
    input  I_ready, O_min, O_max, O_min_idx, O_max_idx, O_valid
  );

  modport slave (
    input  I_data, I_valid, O_ready,
    output I_ready, O_min, O_max, O_min_idx, O_max_idx, O_valid
  );
endinterface

// File: rtl/sint_window_minmax.sv
// rtl/sint_window_minmax.sv - windowed signed min/max tracker with index reporting
//
// Purpose: consumes WINDOW signed samples from a valid/ready stream, tracks the
// signed minimum and maximum and their 0-based positions, then presents one
// result beat on a valid/ready output before starting the next window.
// Ports:
//   CLK    clock, all state updates on the rising edge
//   RESET  synchronous, active-high reset
//   bus    sint_window_minmax_if slave modport (sample input, result output)
module sint_window_minmax #(
  parameter int WIDTH  = 3,
  parameter int WINDOW = 4,
  parameter int IDXW   = 2
) (
  input logic                 CLK,
  input logic                 RESET,
  sint_window_minmax_if.slave bus
);

  typedef enum logic [1:0] {FIRST, ACCUM, HOLD} state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WINDOW - 1);

  state_t                  state;
  logic [IDXW-1:0]         count;
  logic signed [WIDTH-1:0] trk_min, trk_max;
  logic [IDXW-1:0]         trk_min_idx, trk_max_idx;
  logic signed [WIDTH-1:0] nxt_min, nxt_max;
  logic [IDXW-1:0]         nxt_min_idx, nxt_max_idx;
  logic signed [WIDTH-1:0] sample;
  logic [WIDTH-1:0]        o_min, o_max;
  logic [IDXW-1:0]         o_min_idx, o_max_idx;
  logic                    o_valid;
  logic                    accept;
  logic                    last;

  // Ready is a function of state; RESET also gates it so nothing is offered
  // as accepted during the reset cycle.
  assign bus.I_ready = (state != HOLD) && !RESET;
  assign accept      = bus.I_valid && bus.I_ready;
  assign sample      = $signed(bus.I_data);
  // count is 0 in FIRST, so this also covers the WINDOW==1 case.
  assign last        = (count == LAST_IDX);

  // Tracker values including the sample being accepted this cycle.
  always_comb begin
    nxt_min     = trk_min;
    nxt_max     = trk_max;
    nxt_min_idx = trk_min_idx;
    nxt_max_idx = trk_max_idx;
    if (state == FIRST) begin
      nxt_min     = sample;
      nxt_max     = sample;
      nxt_min_idx = '0;
      nxt_max_idx = '0;
    end else begin
      // Strict less-than: ties keep the earlier value and index.
      if (sample < trk_min) begin
        nxt_min     = sample;
        nxt_min_idx = count;
      end
      if (trk_max < sample) begin
        nxt_max     = sample;
        nxt_max_idx = count;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= FIRST;
      count       <= '0;
      trk_min     <= '0;
      trk_max     <= '0;
      trk_min_idx <= '0;
      trk_max_idx <= '0;
      o_min       <= '0;
      o_max       <= '0;
      o_min_idx   <= '0;
      o_max_idx   <= '0;
      o_valid     <= 1'b0;
    end else begin
      case (state)
        FIRST, ACCUM: begin
          if (accept) begin
            trk_min     <= nxt_min;
            trk_max     <= nxt_max;
            trk_min_idx <= nxt_min_idx;
            trk_max_idx <= nxt_max_idx;
            if (last) begin
              // count stays at WINDOW-1 rather than wrapping.
              state     <= HOLD;
              o_min     <= nxt_min;
              o_max     <= nxt_max;
              o_min_idx <= nxt_min_idx;
              o_max_idx <= nxt_max_idx;
              o_valid   <= 1'b1;
            end else begin
              state <= ACCUM;
              count <= count + 1'b1;
            end
          end
        end
        HOLD: begin
          if (o_valid && bus.O_ready) begin
            state   <= FIRST;
            count   <= '0;
            o_valid <= 1'b0;
          end
        end
        default: state <= FIRST;
      endcase
    end
  end

  assign bus.O_min     = o_min;
  assign bus.O_max     = o_max;
  assign bus.O_min_idx = o_min_idx;
  assign bus.O_max_idx = o_max_idx;
  assign bus.O_valid   = o_valid;

endmodule

// File: tb/tb_sint_window_minmax.sv
// tb/tb_sint_window_minmax.sv - directed self-checking bench for sint_window_minmax
module tb_sint_window_minmax;
  localparam int W = 3;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  sint_window_minmax_if #(.WIDTH(W), .IDXW(2)) b4 ();
  sint_window_minmax_if #(.WIDTH(W), .IDXW(1)) b1 ();

  sint_window_minmax #(.WIDTH(W), .WINDOW(4), .IDXW(2)) dut4 (
    .CLK(clk), .RESET(rst), .bus(b4)
  );
  sint_window_minmax #(.WIDTH(W), .WINDOW(1), .IDXW(1)) dut1 (
    .CLK(clk), .RESET(rst), .bus(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task check(input string tag, input int got, input int exp);
    checks = checks + 1;
    if (got != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task tick();
    @(posedge clk);
    #1;
  endtask

  task send(input int v);
    b4.I_data  = W'(v);
    b4.I_valid = 1'b1;
    tick();
  endtask

  task check_beat(input string tag, input int mn, input int mni, input int mx, input int mxi);
    check({tag, "_valid"}, int'(b4.O_valid), 1);
    check({tag, "_iready"}, int'(b4.I_ready), 0);
    check({tag, "_min"}, $signed(b4.O_min), mn);
    check({tag, "_min_idx"}, int'(b4.O_min_idx), mni);
    check({tag, "_max"}, $signed(b4.O_max), mx);
    check({tag, "_max_idx"}, int'(b4.O_max_idx), mxi);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    b4.I_data = '0; b4.I_valid = 1'b0; b4.O_ready = 1'b1;
    b1.I_data = '0; b1.I_valid = 1'b0; b1.O_ready = 1'b1;

    // Reset state
    tick();
    check("rst_iready", int'(b4.I_ready), 0);
    check("rst_ovalid", int'(b4.O_valid), 0);
    check("rst_min", int'(b4.O_min), 0);
    check("rst_max", int'(b4.O_max), 0);
    check("rst_idx", int'(b4.O_min_idx) + int'(b4.O_max_idx), 0);
    check("rst_ovalid_w1", int'(b1.O_valid), 0);
    rst = 1'b0;
    #1;
    check("post_rst_iready", int'(b4.I_ready), 1);

    // Basic window 1,-2,3,0
    send(1); send(-2); send(3); send(0);
    b4.I_valid = 1'b0;
    check_beat("basic", -2, 1, 3, 2);
    check("basic_min_bits", int'(b4.O_min), 6);
    tick();
    check("basic_one_cycle", int'(b4.O_valid), 0);
    check("basic_iready_back", int'(b4.I_ready), 1);

    // Extremes and ties
    send(3); send(-4); send(-4); send(3);
    b4.I_valid = 1'b0;
    check_beat("ext", -4, 1, 3, 0);
    check("ext_min_bits", int'(b4.O_min), 4);
    tick();

    // Backpressure with extra input pulses
    b4.O_ready = 1'b0;
    send(0); send(0); send(0); send(0);
    for (int i = 0; i < 5; i++) begin
      b4.I_data  = W'(3);
      b4.I_valid = 1'b1;
      tick();
      check_beat("bp", 0, 0, 0, 0);
    end
    b4.I_valid = 1'b0;
    b4.O_ready = 1'b1;
    tick();
    check("bp_handoff", int'(b4.O_valid), 0);

    // Gapped input -1,2,-3,1
    send(-1); b4.I_valid = 1'b0; b4.I_data = W'(3); tick();
    send(2);  b4.I_valid = 1'b0; b4.I_data = W'(-4); tick();
    send(-3); b4.I_valid = 1'b0; b4.I_data = W'(3); tick(); tick();
    check("gap_no_early_beat", int'(b4.O_valid), 0);
    send(1);
    b4.I_valid = 1'b0;
    check_beat("gap", -3, 2, 2, 1);
    tick();

    // Reset mid-window
    send(2); send(-1);
    b4.I_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_min", int'(b4.O_min), 0);
    check("mid_rst_max", int'(b4.O_max), 0);
    check("mid_rst_idx", int'(b4.O_min_idx) + int'(b4.O_max_idx), 0);
    check("mid_rst_ovalid", int'(b4.O_valid), 0);
    send(-4); send(-4);
    check("mid_rst_no_stale_beat", int'(b4.O_valid), 0);
    send(-4); send(-4);
    b4.I_valid = 1'b0;
    check_beat("mid_rst", -4, 0, -4, 0);
    tick();
    check("mid_rst_handoff", int'(b4.O_valid), 0);

    // WINDOW=1 build: 3 then -4
    b1.I_data = W'(3);
    b1.I_valid = 1'b1;
    tick();
    check("w1_a_valid", int'(b1.O_valid), 1);
    check("w1_a_iready", int'(b1.I_ready), 0);
    check("w1_a_min", $signed(b1.O_min), 3);
    check("w1_a_max", $signed(b1.O_max), 3);
    check("w1_a_idx", int'(b1.O_min_idx) + int'(b1.O_max_idx), 0);
    b1.I_data = W'(-4);
    tick();
    check("w1_a_handoff", int'(b1.O_valid), 0);
    check("w1_b_iready", int'(b1.I_ready), 1);
    tick();
    b1.I_valid = 1'b0;
    check("w1_b_valid", int'(b1.O_valid), 1);
    check("w1_b_min", $signed(b1.O_min), -4);
    check("w1_b_max", $signed(b1.O_max), -4);
    check("w1_b_idx", int'(b1.O_min_idx) + int'(b1.O_max_idx), 0);
    tick();
    check("w1_b_handoff", int'(b1.O_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
